// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Purpose  : Multicycle MIPS main-control FSM. It sequences fetch, decode,
//            execute, memory and writeback, and decodes the datapath enables.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic       instdone,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] c_SRCB_RT    = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

    localparam logic [1:0] c_ALU_ADD    = 2'b00;
    localparam logic [1:0] c_ALU_SUB    = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT  = 2'b10;
    localparam logic [1:0] c_ALU_ADDI   = 2'b11;

    localparam logic [1:0] c_PC_ALU     = 2'b00;
    localparam logic [1:0] c_PC_ALUOUT  = 2'b01;
    localparam logic [1:0] c_PC_JUMP    = 2'b10;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; encodings 12-15 fall into the default and recover.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) begin
                    w_next = S_MEMADR;
                end else if (op == OP_RTYPE) begin
                    w_next = S_EXEC;
                end else if (op == OP_BEQ) begin
                    w_next = S_BRANCH;
                end else if (op == OP_ADDI) begin
                    w_next = S_ADDIEX;
                end else if (op == OP_J) begin
                    w_next = S_JUMP;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (op == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMRD:  w_next = memready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = memready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore output decode; only the memory-handshake states look at memready.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = c_SRCB_RT;
        aluop       = c_ALU_ADD;
        pcsource    = c_PC_ALU;
        instdone    = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                memread  = 1'b1;
                alusrcb  = c_SRCB_FOUR;
                irwrite  = memready;
                pcwrite  = memready;
            end
            S_DECODE: begin
                alusrcb  = c_SRCB_IMMSH;
                illegal  = !(op == OP_LW || op == OP_SW || op == OP_RTYPE ||
                             op == OP_BEQ || op == OP_ADDI || op == OP_J);
            end
            S_MEMADR: begin
                alusrca  = 1'b1;
                alusrcb  = c_SRCB_IMM;
            end
            S_MEMRD: begin
                memread  = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                instdone = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                instdone = memready;
            end
            S_EXEC: begin
                alusrca  = 1'b1;
                aluop    = c_ALU_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                instdone = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = c_ALU_SUB;
                pcwritecond = 1'b1;
                pcsource    = c_PC_ALUOUT;
                instdone    = 1'b1;
            end
            S_ADDIEX: begin
                alusrca  = 1'b1;
                alusrcb  = c_SRCB_IMM;
                aluop    = c_ALU_ADDI;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                instdone = 1'b1;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = c_PC_JUMP;
                instdone = 1'b1;
            end
            default: begin
                pcwrite = 1'b0;
            end
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Purpose  : Directed table-driven bench for mc_ctrl_fsm plus reset corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       memready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, instdone, illegal;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] state;

    mc_ctrl_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .memready    (memready),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .memtoreg    (memtoreg),
        .regdst      (regdst),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .aluop       (aluop),
        .pcsource    (pcsource),
        .instdone    (instdone),
        .illegal     (illegal),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,
    //  regwrite,alusrca} _ alusrcb _ aluop _ pcsource _ {instdone,illegal}
    localparam logic [17:0] E_FETCH1 = 18'b1001010000_01_00_00_00;
    localparam logic [17:0] E_FETCH0 = 18'b0001000000_01_00_00_00;
    localparam logic [17:0] E_DEC    = 18'b0000000000_11_00_00_00;
    localparam logic [17:0] E_DECILL = 18'b0000000000_11_00_00_01;
    localparam logic [17:0] E_MADR   = 18'b0000000001_10_00_00_00;
    localparam logic [17:0] E_MRD    = 18'b0011000000_00_00_00_00;
    localparam logic [17:0] E_MWB    = 18'b0000001010_00_00_00_10;
    localparam logic [17:0] E_MWR1   = 18'b0010100000_00_00_00_10;
    localparam logic [17:0] E_MWR0   = 18'b0010100000_00_00_00_00;
    localparam logic [17:0] E_EXEC   = 18'b0000000001_00_10_00_00;
    localparam logic [17:0] E_ALUWB  = 18'b0000000110_00_00_00_10;
    localparam logic [17:0] E_BR     = 18'b0100000001_00_01_01_10;
    localparam logic [17:0] E_AIEX   = 18'b0000000001_10_11_00_00;
    localparam logic [17:0] E_AIWB   = 18'b0000000010_00_00_00_10;
    localparam logic [17:0] E_JUMP   = 18'b1000000000_00_00_10_10;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BQ = 6'b000100, OP_AI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] outs;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    function automatic logic [17:0] outs_now();
        return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, aluop, pcsource, instdone, illegal};
    endfunction

    task automatic check(input string name, input logic [3:0] st_exp, input logic [17:0] o_exp);
        checks++;
        if (state !== st_exp || outs_now() !== o_exp) begin
            errors++;
            $display("FAIL %s: state=%0d outs=%b, expected state=%0d outs=%b",
                     name, state, outs_now(), st_exp, o_exp);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic m, input logic [3:0] s, input logic [17:0] e);
        vec_t v;
        v.op = o; v.mr = m; v.st = s; v.outs = e;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // lw: 5 cycles
        add(OP_LW, 1'b1, 4'd0, E_FETCH1); add(OP_LW, 1'b1, 4'd1, E_DEC);
        add(OP_LW, 1'b1, 4'd2, E_MADR);   add(OP_LW, 1'b1, 4'd3, E_MRD);
        add(OP_LW, 1'b1, 4'd4, E_MWB);
        // R-type: 4 cycles
        add(OP_R, 1'b1, 4'd0, E_FETCH1);  add(OP_R, 1'b1, 4'd1, E_DEC);
        add(OP_R, 1'b1, 4'd6, E_EXEC);    add(OP_R, 1'b1, 4'd7, E_ALUWB);
        // beq: 3 cycles, then addi: 4 cycles
        add(OP_BQ, 1'b1, 4'd0, E_FETCH1); add(OP_BQ, 1'b1, 4'd1, E_DEC);
        add(OP_BQ, 1'b1, 4'd8, E_BR);
        add(OP_AI, 1'b1, 4'd0, E_FETCH1); add(OP_AI, 1'b1, 4'd1, E_DEC);
        add(OP_AI, 1'b1, 4'd9, E_AIEX);   add(OP_AI, 1'b1, 4'd10, E_AIWB);
        // sw with 3 fetch stalls and 2 write stalls: 9 cycles
        add(OP_SW, 1'b0, 4'd0, E_FETCH0); add(OP_SW, 1'b0, 4'd0, E_FETCH0);
        add(OP_SW, 1'b0, 4'd0, E_FETCH0); add(OP_SW, 1'b1, 4'd0, E_FETCH1);
        add(OP_SW, 1'b1, 4'd1, E_DEC);    add(OP_SW, 1'b1, 4'd2, E_MADR);
        add(OP_SW, 1'b0, 4'd5, E_MWR0);   add(OP_SW, 1'b0, 4'd5, E_MWR0);
        add(OP_SW, 1'b1, 4'd5, E_MWR1);
        // illegal op: 2 cycles, then jump: 3 cycles
        add(OP_BAD, 1'b1, 4'd0, E_FETCH1); add(OP_BAD, 1'b1, 4'd1, E_DECILL);
        add(OP_J, 1'b1, 4'd0, E_FETCH1);   add(OP_J, 1'b1, 4'd1, E_DEC);
        add(OP_J, 1'b1, 4'd11, E_JUMP);

        // Reset state: FETCH values, write enables low while memready=0
        rst_n = 1'b0; op = OP_LW; memready = 1'b0;
        #12;
        check("reset", 4'd0, E_FETCH0);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            op = vecs[i].op;
            memready = vecs[i].mr;
            #1;
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].outs);
            @(posedge clk);
            #1;
        end

        check("after_jump", 4'd0, E_FETCH1);

        // Async reset in the middle of a MEMRD wait
        op = OP_LW; memready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        memready = 1'b0;
        @(posedge clk);
        #1;
        check("memrd_wait", 4'd3, E_MRD);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 4'd0, E_FETCH0);
        @(posedge clk);
        #1;
        check("rst_held", 4'd0, E_FETCH0);
        rst_n = 1'b1;
        memready = 1'b1;
        #1;
        check("rst_release", 4'd0, E_FETCH1);
        @(posedge clk);
        #1;
        check("post_rst_dec", 4'd1, E_DEC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle main-control state machine for the MIPS CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback, with memory-wait handshaking.
- Drives the datapath enables and the 2-bit aluop consumed by the downstream ALU-control decoder.
- Sits between the instruction register's opcode field and the datapath/ALU-control stage.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch equal
- OP_ADDI, 6'b001000, add immediate
- OP_J, 6'b000010, jump

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode from instruction register, sampled in DECODE
- memready  in  1  memory access complete this cycle
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  PC load if ALU zero
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  instruction register load
- memtoreg  out  1  register write data: 1=MDR, 0=ALUOut
- regdst  out  1  destination register: 1=rd, 0=rt
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A: 0=PC, 1=rs
- alusrcb  out  2  ALU B: 00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
- aluop  out  2  00=add, 01=sub, 10=funct-decoded, 11=addi add
- pcsource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instdone  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  one-cycle pulse in DECODE on an unrecognised op
- state  out  4  current state, for debug

Behaviour:
- State register is 4 bits. It updates on the rising edge of clk.
- rst_n low forces FETCH (0) asynchronously, including mid-instruction and mid-wait.
- Outputs are Moore, decoded from state; FETCH, MEMRD and MEMWR also gate outputs/transitions on memready.
- Any output not listed for a state is 0. Reset output values are the FETCH values.
- FETCH (0):
  - memread=1, alusrcb=01, aluop=00, pcsource=00.
  - irwrite=pcwrite=memready.
  - memready=1 -> DECODE; otherwise stay.
- DECODE (1):
  - alusrcb=11, aluop=00.
  - lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
  - Any other op: illegal=1, next FETCH, no architectural write.
- MEMADR (2): alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD; sw -> MEMWR.
  - op is held stable by the IR, since irwrite=0 outside FETCH.
- MEMRD (3): memread=1, iord=1. memready=1 -> MEMWB; otherwise stay.
- MEMWB (4): regwrite=1, memtoreg=1, regdst=0, instdone=1. Next FETCH.
- MEMWR (5): memwrite=1, iord=1. instdone=memready. memready=1 -> FETCH; otherwise stay.
- EXEC (6): alusrca=1, alusrcb=00, aluop=10. Next ALUWB.
- ALUWB (7): regdst=1, regwrite=1, instdone=1. Next FETCH.
- BRANCH (8): alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, instdone=1. Next FETCH.
- ADDIEX (9): alusrca=1, alusrcb=10, aluop=11. Next ADDIWB.
- ADDIWB (10): regwrite=1, regdst=0, memtoreg=0, instdone=1. Next FETCH.
- JUMP (11): pcwrite=1, pcsource=10, instdone=1. Next FETCH.
- Unused encodings 12-15: all outputs 0, next FETCH (self-recovery).
- Cycle counts with memready always 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Each memready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- memwrite and memread are never both 1. pcwrite and pcwritecond are never both 1.

Test Plan:
- rst_n low mid-MEMRD, released -> state=0 immediately while low; memread=1, aluop=00, alusrcb=01, all write enables 0.
- op=100011, memready tied 1 -> states 0,1,2,3,4; MEMWB shows regwrite=1, memtoreg=1; instdone only in cycle 5.
- op=000000 -> EXEC aluop=10, alusrcb=00; ALUWB regdst=1, regwrite=1; 4 cycles total.
- op=000100 then op=001000 -> BRANCH aluop=01, pcwritecond=1, pcsource=01; ADDIEX aluop=11, alusrcb=10; ADDIWB regwrite=1, regdst=0.
- op=101011 with memready=0 for 3 cycles in FETCH and 2 in MEMWR -> irwrite/pcwrite only on the memready cycle; memwrite held 3 cycles; total 9 cycles.
- op=111111 -> illegal=1 in DECODE, then FETCH, no regwrite/memwrite/pcwrite; op=000010 -> JUMP pcwrite=1, pcsource=10, 3 cycles.
